robertson_ctrl: RTL and testbench

//  Control sequencer for the N-bit Robertson signed shift-add multiplier.

---
 rtl/robertson_ctrl.sv | 151 +++++++++++++++
 tb/tb_robertson_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/robertson_ctrl.sv
// robertson_ctrl
//   Control sequencer for an N-bit Robertson signed shift-add multiplier.
//   Drives load/clear strobes of the M, Q, A, F registers and the adder/shift
//   strobes. It samples Q[0] once per iteration and talks to the host through
//   a start/busy/done handshake.
//
//   Optional feature macro: ROBERTSON_ABORT_EN adds the abort input. When it
//   is defined, abort=1 in any non-IDLE state returns to IDLE on the next edge
//   with no done pulse, and count holds its value.
//
// Ports
//   clk      in   rising-edge clock
//   clear_n  in   asynchronous active-low reset
//   start    in   begin a multiply (sampled only in IDLE)
//   q0       in   current LSB of Q (sampled only in TEST)
//   abort    in   (ROBERTSON_ABORT_EN only) cancel the running operation
//   ld_mq    out  load M and Q from the operand inputs
//   clr_af   out  clear A and F
//   add      out  adder selects A + M
//   sub      out  adder selects A - M (final correction step)
//   ld_af    out  load A from the adder result and update F
//   shift    out  arithmetic right shift of {F,A,Q}
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse; product valid in {A,Q}
//   count    out  current iteration index, 0..N-1
module robertson_ctrl #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          start,
    input  logic          q0,
`ifdef ROBERTSON_ABORT_EN
    input  logic          abort,
`endif
    output logic          ld_mq,
    output logic          clr_af,
    output logic          add,
    output logic          sub,
    output logic          ld_af,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SUB   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic ld_mq;
        logic clr_af;
        logic add;
        logic sub;
        logic ld_af;
        logic shift;
        logic busy;
        logic done;
    } strb_t;

    state_t          state, nxt_state;
    logic [CW-1:0]   nxt_count;
    strb_t           strb;

    // Moore decode of a state's strobes. Applied to the next state so the
    // strobe register always matches the state register.
    function automatic strb_t decode(input state_t s);
        strb_t d;
        d = '0;
        case (s)
            S_LOAD:  begin d.ld_mq = 1'b1; d.clr_af = 1'b1; d.busy = 1'b1; end
            S_TEST:  d.busy = 1'b1;
            S_ADD:   begin d.add = 1'b1; d.ld_af = 1'b1; d.busy = 1'b1; end
            S_SUB:   begin d.sub = 1'b1; d.ld_af = 1'b1; d.busy = 1'b1; end
            S_SHIFT: begin d.shift = 1'b1; d.busy = 1'b1; end
            S_DONE:  begin d.done = 1'b1; d.busy = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_count = count;
        case (state)
            S_IDLE:  if (start) nxt_state = S_LOAD;
            S_LOAD:  begin
                nxt_count = '0;
                nxt_state = S_TEST;
            end
            // The last iteration's multiplier bit carries negative weight,
            // so it becomes a subtraction instead of an addition.
            S_TEST:  begin
                if (!q0)               nxt_state = S_SHIFT;
                else if (count == LAST) nxt_state = S_SUB;
                else                   nxt_state = S_ADD;
            end
            S_ADD,
            S_SUB:   nxt_state = S_SHIFT;
            // count saturates at LAST and holds through DONE and IDLE.
            S_SHIFT: begin
                if (count == LAST) begin
                    nxt_state = S_DONE;
                end else begin
                    nxt_count = count + 1'b1;
                    nxt_state = S_TEST;
                end
            end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
`ifdef ROBERTSON_ABORT_EN
        if (abort && state != S_IDLE) begin
            nxt_state = S_IDLE;
            nxt_count = count;
        end
`endif
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
            count <= '0;
            strb  <= '0;
        end else begin
            state <= nxt_state;
            count <= nxt_count;
            strb  <= decode(nxt_state);
        end
    end

    assign ld_mq  = strb.ld_mq;
    assign clr_af = strb.clr_af;
    assign add    = strb.add;
    assign sub    = strb.sub;
    assign ld_af  = strb.ld_af;
    assign shift  = strb.shift;
    assign busy   = strb.busy;
    assign done   = strb.done;

endmodule

// File: tb/tb_robertson_ctrl.sv
// tb_robertson_ctrl
//   Bench for robertson_ctrl with N=8. A behavioural datapath (extended-width
//   signed accumulator) answers q0 from the strobes. The expected per-cycle
//   strobe sequence is expanded from the multiplier bits, and the product is
//   compared against a plain signed multiply.
module tb_robertson_ctrl;
    localparam int N = 8;

    // Strobe vector packing used by the bench:
    // {ld_mq, clr_af, add, sub, ld_af, shift, busy, done}
    localparam logic [7:0] V_IDLE  = 8'b0000_0000;
    localparam logic [7:0] V_LOAD  = 8'b1100_0010;
    localparam logic [7:0] V_TEST  = 8'b0000_0010;
    localparam logic [7:0] V_ADD   = 8'b0010_1010;
    localparam logic [7:0] V_SUB   = 8'b0001_1010;
    localparam logic [7:0] V_SHIFT = 8'b0000_0110;
    localparam logic [7:0] V_DONE  = 8'b0000_0011;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    logic start = 1'b0;
    logic q0;
`ifdef ROBERTSON_ABORT_EN
    logic abort = 1'b0;
`endif
    logic ld_mq, clr_af, add, sub, ld_af, shift, busy, done;
    logic [$clog2(N)-1:0] count;
    logic [7:0] obs;

    int n_chk = 0;
    int n_pass = 0;
    int cur_cnt = 0;

    always #5 clk = ~clk;

    robertson_ctrl #(.N(N)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .q0(q0),
`ifdef ROBERTSON_ABORT_EN
        .abort(abort),
`endif
        .ld_mq(ld_mq), .clr_af(clr_af), .add(add), .sub(sub), .ld_af(ld_af),
        .shift(shift), .busy(busy), .done(done), .count(count)
    );

    assign obs = {ld_mq, clr_af, add, sub, ld_af, shift, busy, done};

    // Behavioural datapath: {F,A} kept as one N+1-bit signed accumulator.
    logic [N-1:0]        mc_in, mp_in;
    logic [N-1:0]        dm, dq;
    logic signed [N:0]   fa;
    always @(posedge clk) begin
        if (ld_mq) begin dm <= mc_in; dq <= mp_in; end
        if (clr_af) fa <= '0;
        if (add) fa <= fa + $signed({dm[N-1], dm});
        if (sub) fa <= fa - $signed({dm[N-1], dm});
        if (shift) begin
            fa <= fa >>> 1;
            dq <= {fa[0], dq[N-1:1]};
        end
    end
    assign q0 = dq[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full multiply. Expected strobes are expanded from the multiplier:
    // LOAD, then per bit TEST [ADD|SUB] SHIFT, then DONE.
    task automatic run_op(input logic [N-1:0] mc, input logic [N-1:0] mp, input bit hold);
        logic [7:0] ev[$];
        int         ec[$];
        int         done_at;
        int         p;
        logic [31:0] prod;
        ev.push_back(V_LOAD); ec.push_back(cur_cnt);
        for (int i = 0; i < N; i++) begin
            ev.push_back(V_TEST); ec.push_back(i);
            if (mp[i]) begin
                ev.push_back(i < N-1 ? V_ADD : V_SUB); ec.push_back(i);
            end
            ev.push_back(V_SHIFT); ec.push_back(i);
        end
        ev.push_back(V_DONE); ec.push_back(N-1);
        p = $signed(mc) * $signed(mp);
        prod = {16'h0, p[2*N-1:0]};

        mc_in = mc;
        mp_in = mp;
        start = 1'b1;
        done_at = 0;
        for (int k = 0; k < ev.size(); k++) begin
            tick();
            if (!hold) start = 1'b0;
            chk("strobes", {24'h0, obs}, {24'h0, ev[k]});
            chk("count", {29'h0, count}, ec[k]);
            if (done && done_at == 0) done_at = k + 1;
        end
        chk("product", {16'h0, fa[N-1:0], dq}, prod);
        chk("latency", done_at, 2 + 2*N + $countones(mp));
        tick();
        chk("idle_after_done", {24'h0, obs}, {24'h0, V_IDLE});
        chk("count_hold", {29'h0, count}, N-1);
        cur_cnt = N-1;
    endtask

    initial begin
        // Reset state.
        mc_in = '0;
        mp_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", {24'h0, obs}, 32'h0);
        chk("reset_count", {29'h0, count}, 32'h0);
        @(negedge clk);
        clear_n = 1'b1;

        // Asynchronous reset while in SHIFT of iteration 0 (bit0 = 0).
        mc_in = 8'h11;
        mp_in = 8'h02;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("in_shift", {24'h0, obs}, {24'h0, V_SHIFT});
        clear_n = 1'b0;
        #1;
        chk("async_clear_strobes", {24'h0, obs}, 32'h0);
        chk("async_clear_count", {29'h0, count}, 32'h0);
        @(negedge clk);
        clear_n = 1'b1;
        cur_cnt = 0;

        // Directed: all-zero and all-one multipliers, signed corner products.
        run_op(8'h5A, 8'h00, 1'b0);
        run_op(8'h5A, 8'hFF, 1'b0);
        run_op(8'hFD, 8'h05, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);

        // start held high: back-to-back operations with one idle cycle.
        run_op(8'h7F, 8'h81, 1'b1);
        run_op(8'h03, 8'hFE, 1'b1);
        start = 1'b0;

`ifdef ROBERTSON_ABORT_EN
        // Abort in ADD at count 3 (multiplier bit 3 set, bits 0..2 clear).
        mc_in = 8'h27;
        mp_in = 8'h08;
        start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            start = 1'b0;
        end
        chk("abort_in_add", {24'h0, obs}, {24'h0, V_ADD});
        chk("abort_count_before", {29'h0, count}, 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {24'h0, obs}, {24'h0, V_IDLE});
        chk("abort_count_held", {29'h0, count}, 32'd3);
        tick();
        chk("abort_no_done", {24'h0, obs}, {24'h0, V_IDLE});
        cur_cnt = 3;
        run_op(8'h27, 8'h08, 1'b0);
`endif

        // Randomized operands with random idle gaps.
        for (int r = 0; r < 24; r++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            run_op(N'($urandom), N'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
